// File: rtl/turn_signal_sequencer.sv
// turn_signal_sequencer
//   Tail-light controller: sequential-sweep turn signals, hazard flash and
//   brake overlay for LAMPS lamps per side. All timing derives from one
//   divided step tick.
//
// Parameters
//   LAMPS  lamps per side (>=1), bit 0 is the innermost lamp
//   DIV    clock cycles per step tick (>=1)
//   PW     phase width, >= clog2(LAMPS+1)
//
// Ports
//   ADC_CLK_10   in   system clock, rising edge
//   KEY0         in   asynchronous active-low reset
//   turn_en      in   turn signal enable (asynchronous source)
//   turn_right   in   direction, 1=right 0=left (asynchronous source)
//   hazard       in   hazard request (asynchronous source)
//   brake        in   brake request (asynchronous source)
//   left_lamps   out  left lamp drive, registered
//   right_lamps  out  right lamp drive, registered
//   mode         out  0=IDLE 1=LEFT 2=RIGHT 3=HAZARD, registered
//   phase        out  current sequence phase, registered
//   step_tick    out  one-cycle pulse on each step, registered
module turn_signal_sequencer #(
    parameter int LAMPS = 3,
    parameter int DIV   = 4,
    parameter int PW    = 2
) (
    input  logic             ADC_CLK_10,
    input  logic             KEY0,
    input  logic             turn_en,
    input  logic             turn_right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic [1:0]       mode,
    output logic [PW-1:0]    phase,
    output logic             step_tick
);

    localparam int               CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
    localparam logic [PW-1:0]    PH_MAX  = PW'(LAMPS);
    localparam logic [LAMPS-1:0] ALL_ON  = '1;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    // Lowest ph lamps lit: phase 0 is dark, phase LAMPS is fully lit.
    function automatic logic [LAMPS-1:0] sweep_mask(input logic [PW-1:0] ph);
        logic [LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < LAMPS; i++) begin
            m[i] = (i < int'(ph));
        end
        return m;
    endfunction

    // ---- stage p0/p1: two-flop synchronisers, {hazard, brake, turn_right, turn_en}
    logic [3:0] req_p0;
    logic [3:0] req_p1;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            req_p0 <= '0;
            req_p1 <= '0;
        end else begin
            req_p0 <= {hazard, brake, turn_right, turn_en};
            req_p1 <= req_p0;
        end
    end

    logic hazard_s;
    logic brake_s;
    logic turn_right_s;
    logic turn_en_s;

    assign {hazard_s, brake_s, turn_right_s, turn_en_s} = req_p1;

    mode_t req_mode;

    always_comb begin
        req_mode = MODE_IDLE;
        if (hazard_s) begin
            req_mode = MODE_HAZARD;
        end else if (turn_en_s) begin
            req_mode = turn_right_s ? MODE_RIGHT : MODE_LEFT;
        end
    end

    // ---- step divider: the registered tick rises on the same edge the
    // sequencer advances, so mode/phase change coincides with step_tick.
    logic [CW-1:0] div_cnt;
    logic          tick_now;

    assign tick_now = (div_cnt == CNT_MAX);

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            div_cnt   <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= tick_now;
            div_cnt   <= tick_now ? '0 : div_cnt + 1'b1;
        end
    end

    // ---- sequencer: any change of requested mode re-enters at phase 0 (dark)
    mode_t mode_q;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            mode_q <= MODE_IDLE;
            phase  <= '0;
        end else if (tick_now) begin
            if (req_mode != mode_q) begin
                mode_q <= req_mode;
                phase  <= '0;
            end else begin
                case (mode_q)
                    MODE_LEFT,
                    MODE_RIGHT:  phase <= (phase == PH_MAX) ? '0 : phase + 1'b1;
                    MODE_HAZARD: phase <= phase ^ PW'(1);
                    default:     phase <= '0;
                endcase
            end
        end
    end

    assign mode = mode_q;

    // ---- lamp output register
    logic [LAMPS-1:0] side_off;

    assign side_off = brake_s ? ALL_ON : '0;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            left_lamps  <= '0;
            right_lamps <= '0;
        end else begin
            case (mode_q)
                MODE_LEFT: begin
                    left_lamps  <= sweep_mask(phase);
                    right_lamps <= side_off;
                end
                MODE_RIGHT: begin
                    left_lamps  <= side_off;
                    right_lamps <= sweep_mask(phase);
                end
                MODE_HAZARD: begin
                    left_lamps  <= (phase == PW'(1)) ? ALL_ON : '0;
                    right_lamps <= (phase == PW'(1)) ? ALL_ON : '0;
                end
                default: begin
                    left_lamps  <= side_off;
                    right_lamps <= side_off;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_signal_sequencer.sv
module tb_turn_signal_sequencer;

    localparam int LAMPS = 3;
    localparam int DIV   = 4;
    localparam int PW    = 2;
    localparam int FULL  = (1 << LAMPS) - 1;

    logic             clk        = 1'b0;
    logic             KEY0       = 1'b1;
    logic             turn_en    = 1'b0;
    logic             turn_right = 1'b0;
    logic             hazard     = 1'b0;
    logic             brake      = 1'b0;
    logic [LAMPS-1:0] left_lamps;
    logic [LAMPS-1:0] right_lamps;
    logic [1:0]       mode;
    logic [PW-1:0]    phase;
    logic             step_tick;

    int vectors     = 0;
    int miscompares = 0;

    turn_signal_sequencer #(.LAMPS(LAMPS), .DIV(DIV), .PW(PW)) dut (
        .ADC_CLK_10 (clk),
        .KEY0       (KEY0),
        .turn_en    (turn_en),
        .turn_right (turn_right),
        .hazard     (hazard),
        .brake      (brake),
        .left_lamps (left_lamps),
        .right_lamps(right_lamps),
        .mode       (mode),
        .phase      (phase),
        .step_tick  (step_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: requests reach the sequencer two edges after
    // they are sampled (a two-entry delay queue), a step happens on every
    // DIV-th edge after reset release, and the lamps show the state that
    // held before the edge.
    int         m_n     = 0;
    int         m_mode  = 0;
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_right = 0;
    int         m_tick  = 0;
    int         m_req;
    int         m_off;
    int         m_swp;
    logic [3:0] m_used;
    logic [3:0] hist[$];

    always @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            m_n = 0; m_mode = 0; m_phase = 0;
            m_left = 0; m_right = 0; m_tick = 0;
            hist.delete();
            hist.push_back(4'd0);
            hist.push_back(4'd0);
        end else begin
            m_n++;
            m_used = hist.pop_front();
            hist.push_back({hazard, brake, turn_right, turn_en});
            m_off = m_used[2] ? FULL : 0;
            m_swp = (1 << m_phase) - 1;
            case (m_mode)
                1:       begin m_left = m_swp; m_right = m_off; end
                2:       begin m_left = m_off; m_right = m_swp; end
                3:       begin m_left = (m_phase == 1) ? FULL : 0; m_right = m_left; end
                default: begin m_left = m_off; m_right = m_off; end
            endcase
            if (m_used[3])      m_req = 3;
            else if (m_used[0]) m_req = m_used[1] ? 2 : 1;
            else                m_req = 0;
            m_tick = (m_n % DIV == 0) ? 1 : 0;
            if (m_tick == 1) begin
                if (m_req != m_mode) begin
                    m_mode  = m_req;
                    m_phase = 0;
                end else if (m_mode == 1 || m_mode == 2) begin
                    m_phase = (m_phase + 1) % (LAMPS + 1);
                end else if (m_mode == 3) begin
                    m_phase = 1 - m_phase;
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #3;
        check("model_left",  32'(left_lamps),  32'(m_left));
        check("model_right", 32'(right_lamps), 32'(m_right));
        check("model_mode",  32'(mode),        32'(m_mode));
        check("model_phase", 32'(phase),       32'(m_phase));
        check("model_tick",  32'(step_tick),   32'(m_tick));
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 4 * DIV * (LAMPS + 1) && !found; k++) begin
            at_edge();
            found = step_tick;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick: step_tick=0 after budget, want 1");
        end
    endtask

    task automatic check_lamps(input string name, input int l, input int r);
        check({name, "_left"},  32'(left_lamps),  32'(l));
        check({name, "_right"}, 32'(right_lamps), 32'(r));
    endtask

    initial begin
        // Reset with every request high: outputs clear without a clock edge.
        turn_en = 1; turn_right = 1; hazard = 1; brake = 1;
        #1 KEY0 = 1'b0;
        #1;
        check_lamps("rst", 0, 0);
        check("rst_mode",  32'(mode),      0);
        check("rst_phase", 32'(phase),     0);
        check("rst_tick",  32'(step_tick), 0);
        repeat (2) at_edge();
        turn_en = 0; turn_right = 0; hazard = 0; brake = 0;
        @(negedge clk) KEY0 = 1'b1;
        for (int e = 1; e <= DIV; e++) begin
            at_edge();
            check("first_tick", 32'(step_tick), (e == DIV) ? 1 : 0);
        end

        // Right sweep.
        turn_en = 1; turn_right = 1;
        wait_tick();
        check("right_mode", 32'(mode), 2);
        check("right_ph0",  32'(phase), 0);
        at_edge(); check_lamps("right0", 0, 0);
        wait_tick(); at_edge(); check_lamps("right1", 0, 1);
        wait_tick();
        check("right_ph2", 32'(phase), 2);
        at_edge(); check_lamps("right2", 0, 3);

        // Reverse at phase 2: left restarts dark.
        turn_right = 0;
        wait_tick();
        check("rev_mode", 32'(mode), 1);
        check("rev_ph",   32'(phase), 0);
        at_edge(); check_lamps("rev0", 0, 0);
        wait_tick(); at_edge(); check_lamps("left1", 1, 0);
        wait_tick(); at_edge(); check_lamps("left2", 3, 0);
        wait_tick(); at_edge(); check_lamps("left3", 7, 0);

        // Hazard with brake: brake has no effect.
        hazard = 1; brake = 1;
        wait_tick();
        check("haz_mode", 32'(mode), 3);
        at_edge(); check_lamps("haz0", 0, 0);
        wait_tick(); at_edge(); check_lamps("haz1", 7, 7);
        wait_tick(); at_edge(); check_lamps("haz2", 0, 0);

        // Left sweep with brake: right side solid.
        hazard = 0;
        wait_tick();
        check("brk_mode", 32'(mode), 1);
        at_edge(); check_lamps("brk0", 0, 7);
        wait_tick(); at_edge(); check_lamps("brk1", 1, 7);

        // Idle with brake, then release brake: three edges to go dark.
        turn_en = 0;
        wait_tick();
        check("idle_mode", 32'(mode), 0);
        at_edge(); check_lamps("idle_brk", 7, 7);
        brake = 0;
        at_edge(); check_lamps("brk_rel1", 7, 7);
        at_edge(); check_lamps("brk_rel2", 7, 7);
        at_edge(); check_lamps("brk_rel3", 0, 0);

        // Reset mid-hazard at phase 1.
        hazard = 1;
        wait_tick();
        wait_tick();
        check("haz_ph1", 32'(phase), 1);
        at_edge(); check_lamps("haz_on", 7, 7);
        #1 KEY0 = 1'b0;
        #1;
        check_lamps("mid_rst", 0, 0);
        check("mid_rst_mode",  32'(mode),  0);
        check("mid_rst_phase", 32'(phase), 0);
        @(negedge clk) KEY0 = 1'b1;
        for (int e = 1; e <= DIV; e++) begin
            at_edge();
            check("rst_tick2", 32'(step_tick), (e == DIV) ? 1 : 0);
            check("rst_mode2", 32'(mode), (e == DIV) ? 3 : 0);
        end

        // Randomised requests with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) turn_en    = ~turn_en;
            if ($urandom_range(0, 29) == 0) turn_right = ~turn_right;
            if ($urandom_range(0, 59) == 0) hazard     = ~hazard;
            if ($urandom_range(0, 24) == 0) brake      = ~brake;
            if ($urandom_range(0, 499) == 0) begin
                KEY0 = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                KEY0 = 1'b1;
            end
        end

        at_edge();
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
